alu_op_sequencer: RTL and testbench

- **Function:** Command-driven controller that sequences the existing 16-bit ALU (`ALU_16_bits`).
- **Operands:** Holds a 4x16 register file that supplies A and B.
- **Carry:** Keeps a 6-bit flag register. Its carry bit drives the ALU `Cin`, so ADC/SBB/RCL/RCR chain across commands.
- **Repeat:** Each command runs the selected ALU function 1 to 16 times, feeding the result back as A each time. This gives multi-bit shifts and rotates on top of the ALU's single-step ones.
- **Output:** Every command returns its result and flags through a ready/valid response port.

---
 rtl/alu_seq_pkg.sv | 38 +++
 rtl/ALU_16_bits.sv | 75 +++++++
 rtl/alu_op_sequencer.sv | 125 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg -- shared definitions for the ALU operation sequencer.
//   * 5-bit ALU function codes understood by ALU_16_bits, plus OP_LOAD
//   * sequencer state encoding
//   * register-file geometry and data/flag widths
package alu_seq_pkg;

  localparam int DATA_W   = 16;
  localparam int FLAG_W   = 6;
  localparam int RF_DEPTH = 4;
  localparam int RF_IDX_W = 2;

  localparam logic [4:0] OP_INC  = 5'b00001;
  localparam logic [4:0] OP_DEC  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADC  = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SBB  = 5'b00111;
  localparam logic [4:0] OP_AND  = 5'b01000;
  localparam logic [4:0] OP_OR   = 5'b01001;
  localparam logic [4:0] OP_XOR  = 5'b01010;
  localparam logic [4:0] OP_NOT  = 5'b01011;
  localparam logic [4:0] OP_SHL  = 5'b10000;
  localparam logic [4:0] OP_SHR  = 5'b10001;
  localparam logic [4:0] OP_SAL  = 5'b10010;
  localparam logic [4:0] OP_SAR  = 5'b10011;
  localparam logic [4:0] OP_ROL  = 5'b10100;
  localparam logic [4:0] OP_ROR  = 5'b10101;
  localparam logic [4:0] OP_RCL  = 5'b10110;
  localparam logic [4:0] OP_RCR  = 5'b10111;
  localparam logic [4:0] OP_LOAD = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/ALU_16_bits.sv
// ALU_16_bits -- single-step 16-bit combinational ALU.
// Ports (positional order): Result[15:0], Status[5:0], A[15:0], B[15:0],
//   F[4:0] function code, Cin carry in (used by ADC/SBB/RCL/RCR).
// Status bits: [0] carry/borrow, [1] zero, [2] sign, [3] overflow,
//   [4] even parity, [5] auxiliary carry (bit 3 -> 4, add/sub family only).
// Unlisted function codes return A unchanged.
module ALU_16_bits
  import alu_seq_pkg::*;
(
  output logic [15:0] Result,
  output logic [5:0]  Status,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [4:0]  F,
  input  logic        Cin
);

  logic [16:0] wide;
  logic [15:0] op2;
  logic        carry;
  logic        ovf;
  logic        arith;
  logic        af;

  always_comb begin
    wide   = '0;
    op2    = B;
    carry  = 1'b0;
    ovf    = 1'b0;
    arith  = 1'b0;
    Result = A;
    case (F)
      OP_INC: begin
        op2 = 16'h0001; arith = 1'b1;
        wide = {1'b0, A} + 17'd1;
        Result = wide[15:0]; carry = wide[16];
        ovf = (A == 16'h7FFF);
      end
      OP_DEC: begin
        op2 = 16'h0001; arith = 1'b1;
        wide = {1'b0, A} - 17'd1;
        Result = wide[15:0]; carry = wide[16];
        ovf = (A == 16'h8000);
      end
      OP_ADD, OP_ADC: begin
        arith = 1'b1;
        wide = {1'b0, A} + {1'b0, B} + {16'b0, (F == OP_ADC) & Cin};
        Result = wide[15:0]; carry = wide[16];
        ovf = (A[15] == B[15]) && (Result[15] != A[15]);
      end
      OP_SUB, OP_SBB: begin
        arith = 1'b1;
        wide = {1'b0, A} - {1'b0, B} - {16'b0, (F == OP_SBB) & Cin};
        Result = wide[15:0]; carry = wide[16];
        ovf = (A[15] != B[15]) && (Result[15] != A[15]);
      end
      OP_AND: Result = A & B;
      OP_OR:  Result = A | B;
      OP_XOR: Result = A ^ B;
      OP_NOT: Result = ~A;
      OP_SHL: begin Result = {A[14:0], 1'b0};  carry = A[15]; end
      OP_SAL: begin Result = {A[14:0], 1'b0};  carry = A[15]; ovf = A[15] ^ A[14]; end
      OP_SHR: begin Result = {1'b0, A[15:1]};  carry = A[0]; end
      OP_SAR: begin Result = {A[15], A[15:1]}; carry = A[0]; end
      OP_ROL: begin Result = {A[14:0], A[15]}; carry = A[15]; end
      OP_ROR: begin Result = {A[0], A[15:1]};  carry = A[0]; end
      OP_RCL: begin Result = {A[14:0], Cin};   carry = A[15]; end
      OP_RCR: begin Result = {Cin, A[15:1]};   carry = A[0]; end
      default: Result = A;
    endcase
    af = arith & (A[4] ^ op2[4] ^ Result[4]);
    Status = {af, ~^Result, ovf, Result[15], (Result == 16'h0000), carry};
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer -- command-driven controller around ALU_16_bits.
// Holds a 4x16 register file and a 6-bit flag register whose carry bit
// feeds the ALU carry-in, so carry-chained ops continue across commands.
// An ALU command may repeat its function N+1 times, feeding the result
// back as A (multi-bit shifts/rotates from single-step ALU ops).
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cmd_valid/ready     command handshake
//   cmd_op              ALU function code, OP_LOAD (11111) loads cmd_imm
//   cmd_dst/srca/srcb   register indices
//   cmd_count           repeat count N (N+1 iterations)
//   cmd_imm             immediate for OP_LOAD
//   rsp_valid/ready     response handshake
//   rsp_data/rsp_flags  final result and flag register
//
// Configuration macro ALU_SEQ_REPEAT_EN: when defined cmd_count is honoured;
// when undefined every ALU command runs a single iteration.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int CF_BIT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [4:0]          cmd_op,
  input  logic [RF_IDX_W-1:0] cmd_dst,
  input  logic [RF_IDX_W-1:0] cmd_srca,
  input  logic [RF_IDX_W-1:0] cmd_srcb,
  input  logic [3:0]          cmd_count,
  input  logic [DATA_W-1:0]   cmd_imm,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [FLAG_W-1:0]   rsp_flags
);

  state_e              state_q;
  logic [DATA_W-1:0]   rf_q [RF_DEPTH];
  logic [DATA_W-1:0]   acc_q;
  logic [DATA_W-1:0]   opb_q;
  logic [4:0]          op_q;
  logic [RF_IDX_W-1:0] dst_q;
  logic [FLAG_W-1:0]   flags_q;

  logic [DATA_W-1:0]   alu_result;
  logic [FLAG_W-1:0]   alu_status;
  logic                last_iter;

`ifdef ALU_SEQ_REPEAT_EN
  logic [3:0]          cnt_q;
  assign last_iter = (cnt_q == 4'd0);
`else
  logic                unused_count;
  assign unused_count = ^cmd_count;
  assign last_iter    = 1'b1;
`endif

  ALU_16_bits u_alu (alu_result, alu_status, acc_q, opb_q, op_q, flags_q[CF_BIT]);

  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = acc_q;
  assign rsp_flags = flags_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      dst_q   <= '0;
      flags_q <= '0;
`ifdef ALU_SEQ_REPEAT_EN
      cnt_q   <= '0;
`endif
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
    end else begin
      case (state_q)
        // Accept: operands are captured here so later write-back to an
        // aliased register cannot disturb this command.
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_op == OP_LOAD) begin
              rf_q[cmd_dst] <= cmd_imm;
              acc_q         <= cmd_imm;
              state_q       <= ST_RESP;
            end else begin
              acc_q   <= rf_q[cmd_srca];
              opb_q   <= rf_q[cmd_srcb];
              op_q    <= cmd_op;
              dst_q   <= cmd_dst;
`ifdef ALU_SEQ_REPEAT_EN
              cnt_q   <= cmd_count;
`endif
              state_q <= ST_EXEC;
            end
          end
        end
        // Execute: one ALU step per edge, result and carry fed back.
        ST_EXEC: begin
          acc_q   <= alu_result;
          flags_q <= alu_status;
          if (last_iter) begin
            rf_q[dst_q] <= alu_result;
            state_q     <= ST_RESP;
          end
`ifdef ALU_SEQ_REPEAT_EN
          else begin
            cnt_q <= cnt_q - 4'd1;
          end
`endif
        end
        // Respond: acc/flags hold until the consumer takes them.
        ST_RESP: begin
          if (rsp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_op;
  logic [1:0]  cmd_dst, cmd_srca, cmd_srcb;
  logic [3:0]  cmd_count;
  logic [15:0] cmd_imm;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [5:0]  rsp_flags;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] data;
    logic [5:0]  flags;
  } exp_t;
  exp_t exp_q[$];

`ifdef ALU_SEQ_REPEAT_EN
  localparam int          SHL3_LAT = 5;
  localparam logic [15:0] SHL3_RES = 16'h0010;
`else
  localparam int          SHL3_LAT = 2;
  localparam logic [15:0] SHL3_RES = 16'h0002;
`endif

  alu_op_sequencer #(.CF_BIT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
    .cmd_count(cmd_count), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per response handshake.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got data 0x%0h, expected no response", rsp_data);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", {16'h0, rsp_data}, {16'h0, e.data});
        chk("rsp_flags", {26'h0, rsp_flags}, {26'h0, e.flags});
      end
    end
  end

  // Present a command at a negedge; returns right after its accepting edge.
  task automatic send_cmd(input logic [4:0] op, input logic [1:0] dst, input logic [1:0] sa,
                          input logic [1:0] sb, input logic [3:0] n, input logic [15:0] imm);
    int t = 0;
    cmd_op = op; cmd_dst = dst; cmd_srca = sa; cmd_srcb = sb; cmd_count = n; cmd_imm = imm;
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got cmd_ready 0, expected 1 within 50 cycles");
    end
    @(posedge clk);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (!(exp_q.size() == 0 && cmd_ready) && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  task automatic run_cmd(input string name, input logic [4:0] op, input logic [1:0] dst,
                         input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] n,
                         input logic [15:0] imm, input logic [15:0] ed, input logic [5:0] ef,
                         input int elat);
    int lat;
    exp_q.push_back('{data: ed, flags: ef});
    send_cmd(op, dst, sa, sb, n, imm);
    lat = 1;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({name, "_latency"}, lat, elat);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200us");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_op = '0; cmd_dst = '0; cmd_srca = '0; cmd_srcb = '0; cmd_count = '0; cmd_imm = '0;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_flags", rsp_flags, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD and register write-back
    run_cmd("load_r0", OP_LOAD, 2'd0, 2'd0, 2'd0, 4'd5, 16'h0003, 16'h0003, 6'h00, 1);
    run_cmd("load_r1", OP_LOAD, 2'd1, 2'd0, 2'd0, 4'd0, 16'h0004, 16'h0004, 6'h00, 1);
    run_cmd("add",     OP_ADD,  2'd2, 2'd0, 2'd1, 4'd0, 16'h0000, 16'h0007, 6'h00, 2);
    run_cmd("or_r2",   OP_OR,   2'd2, 2'd2, 2'd2, 4'd0, 16'h0000, 16'h0007, 6'h00, 2);

    // Repeated shift
    run_cmd("load_r0b", OP_LOAD, 2'd0, 2'd0, 2'd0, 4'd0, 16'h0001, 16'h0001, 6'h00, 1);
    run_cmd("shl_n3",   OP_SHL,  2'd0, 2'd0, 2'd0, 4'd3, 16'h0000, SHL3_RES, 6'h00, SHL3_LAT);

    // Carry chain
    run_cmd("load_ffff", OP_LOAD, 2'd0, 2'd0, 2'd0, 4'd0, 16'hFFFF, 16'hFFFF, 6'h00, 1);
    run_cmd("load_1",    OP_LOAD, 2'd1, 2'd0, 2'd0, 4'd0, 16'h0001, 16'h0001, 6'h00, 1);
    run_cmd("add_carry", OP_ADD,  2'd0, 2'd0, 2'd1, 4'd0, 16'h0000, 16'h0000, 6'h33, 2);
    run_cmd("adc",       OP_ADC,  2'd3, 2'd1, 2'd1, 4'd0, 16'h0000, 16'h0003, 6'h10, 2);

    // Backpressure: response held, next command waits
    rsp_ready = 1'b0;
    exp_q.push_back('{data: 16'h1234, flags: 6'h10});
    send_cmd(OP_LOAD, 2'd2, 2'd0, 2'd0, 4'd0, 16'h1234);
    @(negedge clk);
    cmd_op = OP_ADD; cmd_dst = 2'd1; cmd_srca = 2'd3; cmd_srcb = 2'd2; cmd_count = 4'd0;
    cmd_valid = 1'b1;
    exp_q.push_back('{data: 16'h1237, flags: 6'h00});
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, 16'h1234);
      chk("bp_rsp_flags", rsp_flags, 6'h10);
      chk("bp_cmd_ready", cmd_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_ready_after_hs", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    chk("bp_accepted", cmd_ready, 0);
    cmd_valid = 1'b0;
    wait_drain();

    // Reset in the middle of a long shift
    run_cmd("load_r0c", OP_LOAD, 2'd0, 2'd0, 2'd0, 4'd0, 16'h0001, 16'h0001, 6'h00, 1);
    rsp_ready = 1'b0;
    send_cmd(OP_SHL, 2'd0, 2'd0, 2'd0, 4'd7, 16'h0000);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_rsp_flags", rsp_flags, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    run_cmd("post_rst_adc", OP_ADC, 2'd0, 2'd0, 2'd1, 4'd0, 16'h0000, 16'h0000, 6'h12, 2);
    run_cmd("post_rst_or",  OP_OR,  2'd1, 2'd2, 2'd3, 4'd0, 16'h0000, 16'h0000, 6'h12, 2);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
